adc_average_multi: RTL and testbench

Multi-channel, run-time configurable boxcar averager for the ADC front end in ADC_CLK domain. It accumulates 2^L consecutive samples on every channel in parallel, with L selectable per run up to a build-time maximum. It emits a rounded mean per channel with a one-cycle DONE strobe, in one-shot or gap-free continuous mode. It is the generalised successor to the fixed 1024-sample single-channel averager feeding the DAC loop: it sits between the ADC capture register and the downstream loop/DAC logic.

---
 rtl/adc_average_multi.sv | 129 ++++++++++++
 tb/tb_adc_average_multi.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_average_multi.sv
// adc_average_multi
//   Multi-channel boxcar averager in the ADC_CLK domain. It sums 2^L
//   consecutive samples on every channel in parallel and emits a rounded
//   mean per channel. The mean rounds half-up, toward +inf. L is latched
//   when a run starts. Runs are one-shot, or gap-free when CONT is held.
//
// Ports
//   ADC_CLK      sole clock, rising edge
//   RST          synchronous active-high reset
//   ADC_DATA_IN  packed samples, channel c at [c*ADC_WIDTH +: ADC_WIDTH]
//   DATA_SIGNED  1 = two's complement samples; latched at run start
//   LOG2_N_IN    requested L; latched at run start, clamped to MAX_LOG2_N
//   START        level; sampled only while idle
//   CONT         continuous request; sampled at each window end
//   AVE_OUT      registered per-channel mean, same packing as ADC_DATA_IN
//   DONE         one-cycle pulse when AVE_OUT is newly valid
//   BUSY         high while accumulating
module adc_average_multi #(
  parameter int ADC_WIDTH  = 12,
  parameter int NUM_CH     = 2,
  parameter int MAX_LOG2_N = 10,
  parameter int LOG2_WIDTH = 4
) (
  input  logic                          ADC_CLK,
  input  logic                          RST,
  input  logic [NUM_CH*ADC_WIDTH-1:0]   ADC_DATA_IN,
  input  logic                          DATA_SIGNED,
  input  logic [LOG2_WIDTH-1:0]         LOG2_N_IN,
  input  logic                          START,
  input  logic                          CONT,
  output logic [NUM_CH*ADC_WIDTH-1:0]   AVE_OUT,
  output logic                          DONE,
  output logic                          BUSY
);

  localparam int AW = ADC_WIDTH + MAX_LOG2_N + 1;
  localparam int CW = MAX_LOG2_N;

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t                  state;
  logic [LOG2_WIDTH-1:0]   lat_l;
  logic                    lat_signed;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_last;
  logic [AW-1:0]           acc [NUM_CH];

  logic [LOG2_WIDTH-1:0]   l_clamp;
  logic [CW-1:0]           last_next;
  logic [AW-1:0]           half;
  logic                    win_end;
  logic [ADC_WIDTH-1:0]    smp [NUM_CH];
  logic [AW-1:0]           ext [NUM_CH];
  logic [AW-1:0]           sum [NUM_CH];
  logic [AW-1:0]           rnd [NUM_CH];
  logic [NUM_CH*ADC_WIDTH-1:0] ave_next;

  always_comb begin
    l_clamp = (LOG2_N_IN > LOG2_WIDTH'(MAX_LOG2_N)) ? LOG2_WIDTH'(MAX_LOG2_N)
                                                    : LOG2_N_IN;
    // Terminal count 2^L-1 is precomputed at run start so the window-end
    // compare is a plain equality.
    last_next = CW'((32'd1 << l_clamp) - 32'd1);
    half = '0;
    if (lat_l != '0) half = AW'(1) << (lat_l - LOG2_WIDTH'(1));
    win_end  = (cnt == cnt_last);
    ave_next = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      smp[c] = ADC_DATA_IN[c*ADC_WIDTH +: ADC_WIDTH];
      ext[c] = lat_signed ? {{(AW-ADC_WIDTH){smp[c][ADC_WIDTH-1]}}, smp[c]}
                          : {{(AW-ADC_WIDTH){1'b0}}, smp[c]};
      // First sample of a window replaces the stale sum instead of adding.
      sum[c] = ((cnt == '0) ? '0 : acc[c]) + ext[c];
      rnd[c] = sum[c] + half;
      // Separate branches keep the arithmetic shift in a signed context.
      if (lat_signed)
        ave_next[c*ADC_WIDTH +: ADC_WIDTH] = ADC_WIDTH'($signed(rnd[c]) >>> lat_l);
      else
        ave_next[c*ADC_WIDTH +: ADC_WIDTH] = ADC_WIDTH'(rnd[c] >> lat_l);
    end
  end

  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      lat_l      <= '0;
      lat_signed <= 1'b0;
      cnt        <= '0;
      cnt_last   <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= '0;
      AVE_OUT    <= '0;
      DONE       <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            lat_l      <= l_clamp;
            lat_signed <= DATA_SIGNED;
            cnt_last   <= last_next;
            cnt        <= '0;
            state      <= S_ACCUM;
            BUSY       <= 1'b1;
          end
        end
        S_ACCUM: begin
          for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= sum[c];
          if (win_end) begin
            AVE_OUT <= ave_next;
            DONE    <= 1'b1;
            cnt     <= '0;
            if (!CONT) begin
              state <= S_IDLE;
              BUSY  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_average_multi.sv
// Directed self-checking bench for adc_average_multi (default parameters).
module tb_adc_average_multi;

  logic        ADC_CLK = 1'b0;
  logic        RST = 1'b1;
  logic [23:0] ADC_DATA_IN = '0;
  logic        DATA_SIGNED = 1'b0;
  logic [3:0]  LOG2_N_IN = '0;
  logic        START = 1'b0;
  logic        CONT = 1'b0;
  logic [23:0] AVE_OUT;
  logic        DONE;
  logic        BUSY;

  int n_checks = 0;
  int n_pass   = 0;
  int early_done;

  logic [11:0] samp0 [1024];
  logic [11:0] samp1 [1024];

  adc_average_multi #(
    .ADC_WIDTH(12), .NUM_CH(2), .MAX_LOG2_N(10), .LOG2_WIDTH(4)
  ) dut (
    .ADC_CLK(ADC_CLK), .RST(RST), .ADC_DATA_IN(ADC_DATA_IN),
    .DATA_SIGNED(DATA_SIGNED), .LOG2_N_IN(LOG2_N_IN), .START(START),
    .CONT(CONT), .AVE_OUT(AVE_OUT), .DONE(DONE), .BUSY(BUSY)
  );

  always #5 ADC_CLK = ~ADC_CLK;

  task automatic tick();
    @(posedge ADC_CLK);
    #1;
  endtask

  // One-shot run: START edge, then n samples from samp0/samp1. Changes
  // LOG2_N_IN and DATA_SIGNED mid-run; the latched values must win.
  task automatic drive_window(input int n, input logic [3:0] l, input logic sgn);
    LOG2_N_IN = l; DATA_SIGNED = sgn; CONT = 1'b0; START = 1'b1;
    tick();
    START = 1'b0; LOG2_N_IN = 4'd0; DATA_SIGNED = ~sgn;
    early_done = 0;
    for (int i = 0; i < n; i++) begin
      ADC_DATA_IN = {samp1[i], samp0[i]};
      tick();
      if (i < n - 1 && DONE) early_done++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    n_checks++; if (AVE_OUT !== 24'h0) $display("FAIL reset_ave got %h want %h", AVE_OUT, 24'h0); else n_pass++;
    n_checks++; if (DONE !== 1'b0) $display("FAIL reset_done got %b want 0", DONE); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", BUSY); else n_pass++;
    RST = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin samp0[i] = 12'd100; samp1[i] = 12'hFFF; end
    drive_window(4, 4'd2, 1'b0);
    n_checks++; if (early_done !== 0) $display("FAIL basic_early_done got %0d want 0", early_done); else n_pass++;
    n_checks++; if (DONE !== 1'b1) $display("FAIL basic_done got %b want 1", DONE); else n_pass++;
    n_checks++; if (AVE_OUT !== {12'hFFF, 12'd100}) $display("FAIL basic_ave got %h want %h", AVE_OUT, {12'hFFF, 12'd100}); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL basic_busy got %b want 0", BUSY); else n_pass++;
    tick();
    n_checks++; if (DONE !== 1'b0) $display("FAIL basic_done_single got %b want 0", DONE); else n_pass++;
    n_checks++; if (AVE_OUT !== {12'hFFF, 12'd100}) $display("FAIL basic_hold got %h want %h", AVE_OUT, {12'hFFF, 12'd100}); else n_pass++;
  endtask

  task automatic test_rounding();
    // unsigned: ch0 1,2,2,1 -> (6+2)>>2 = 2 ; ch1 1,1,1,2 -> (5+2)>>2 = 1
    samp0[0] = 12'd1; samp0[1] = 12'd2; samp0[2] = 12'd2; samp0[3] = 12'd1;
    samp1[0] = 12'd1; samp1[1] = 12'd1; samp1[2] = 12'd1; samp1[3] = 12'd2;
    drive_window(4, 4'd2, 1'b0);
    n_checks++; if (AVE_OUT !== {12'd1, 12'd2}) $display("FAIL round_unsigned got %h want %h", AVE_OUT, {12'd1, 12'd2}); else n_pass++;
    tick();
    // signed: ch0 -1,-2,-2,-1 -> (-6+2)>>>2 = -1 ; ch1 2047 x4 -> 2047
    samp0[0] = 12'hFFF; samp0[1] = 12'hFFE; samp0[2] = 12'hFFE; samp0[3] = 12'hFFF;
    for (int i = 0; i < 4; i++) samp1[i] = 12'h7FF;
    drive_window(4, 4'd2, 1'b1);
    n_checks++; if (DONE !== 1'b1) $display("FAIL round_signed_done got %b want 1", DONE); else n_pass++;
    n_checks++; if (AVE_OUT !== {12'h7FF, 12'hFFF}) $display("FAIL round_signed got %h want %h", AVE_OUT, {12'h7FF, 12'hFFF}); else n_pass++;
    tick();
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 1024; i++) begin samp0[i] = 12'hFFF; samp1[i] = 12'hFFF; end
    drive_window(1024, 4'd15, 1'b0);
    n_checks++; if (early_done !== 0) $display("FAIL clamp_early_done got %0d want 0", early_done); else n_pass++;
    n_checks++; if (DONE !== 1'b1) $display("FAIL clamp_done got %b want 1", DONE); else n_pass++;
    n_checks++; if (AVE_OUT !== 24'hFFF_FFF) $display("FAIL clamp_unsigned got %h want %h", AVE_OUT, 24'hFFF_FFF); else n_pass++;
    tick();
    for (int i = 0; i < 1024; i++) begin samp0[i] = 12'h800; samp1[i] = 12'h800; end
    drive_window(1024, 4'd15, 1'b1);
    n_checks++; if (DONE !== 1'b1) $display("FAIL clamp_signed_done got %b want 1", DONE); else n_pass++;
    n_checks++; if (AVE_OUT !== 24'h800_800) $display("FAIL clamp_signed got %h want %h", AVE_OUT, 24'h800_800); else n_pass++;
    tick();
  endtask

  task automatic test_continuous();
    int wrong_done;
    int done_after;
    logic [11:0] e0, e1;
    wrong_done = 0;
    LOG2_N_IN = 4'd3; DATA_SIGNED = 1'b0; CONT = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    for (int cyc = 1; cyc <= 32; cyc++) begin
      if (cyc == 25) CONT = 1'b0;
      ADC_DATA_IN = {12'hFFF - 12'(cyc - 1), 12'(cyc - 1)};
      tick();
      if (cyc % 8 == 0) begin
        e0 = 12'(8 * (cyc / 8 - 1) + 4);
        e1 = 12'(4092 - 8 * (cyc / 8 - 1));
        n_checks++; if (DONE !== 1'b1) $display("FAIL cont_done_w%0d got %b want 1", cyc / 8, DONE); else n_pass++;
        n_checks++; if (AVE_OUT !== {e1, e0}) $display("FAIL cont_ave_w%0d got %h want %h", cyc / 8, AVE_OUT, {e1, e0}); else n_pass++;
        if (cyc < 32) begin
          n_checks++; if (BUSY !== 1'b1) $display("FAIL cont_busy_w%0d got %b want 1", cyc / 8, BUSY); else n_pass++;
        end
      end else if (DONE !== 1'b0) begin
        wrong_done++;
      end
    end
    n_checks++; if (wrong_done !== 0) $display("FAIL cont_spurious_done got %0d want 0", wrong_done); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL cont_stop_busy got %b want 0", BUSY); else n_pass++;
    done_after = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (DONE) done_after++; end
    n_checks++; if (done_after !== 0) $display("FAIL cont_stop_done got %0d want 0", done_after); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int d;
    LOG2_N_IN = 4'd4; DATA_SIGNED = 1'b0; CONT = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    d = 0;
    ADC_DATA_IN = {12'd7, 12'd500};
    for (int i = 0; i < 7; i++) begin tick(); if (DONE) d++; end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_checks++; if (d !== 0) $display("FAIL rstmid_early_done got %0d want 0", d); else n_pass++;
    n_checks++; if (AVE_OUT !== 24'h0) $display("FAIL rstmid_ave got %h want %h", AVE_OUT, 24'h0); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL rstmid_busy got %b want 0", BUSY); else n_pass++;
    n_checks++; if (DONE !== 1'b0) $display("FAIL rstmid_done got %b want 0", DONE); else n_pass++;
    // fresh run: ch0 0..15 -> (120+8)>>4 = 8 ; ch1 3 x16 -> 3
    for (int i = 0; i < 16; i++) begin samp0[i] = 12'(i); samp1[i] = 12'd3; end
    drive_window(16, 4'd4, 1'b0);
    n_checks++; if (early_done !== 0) $display("FAIL rstmid_run_early got %0d want 0", early_done); else n_pass++;
    n_checks++; if (DONE !== 1'b1) $display("FAIL rstmid_run_done got %b want 1", DONE); else n_pass++;
    n_checks++; if (AVE_OUT !== {12'd3, 12'd8}) $display("FAIL rstmid_run_ave got %h want %h", AVE_OUT, {12'd3, 12'd8}); else n_pass++;
    tick();
  endtask

  task automatic test_l0_passthrough();
    int bad_done;
    int bad_ave;
    logic [23:0] v;
    bad_done = 0; bad_ave = 0;
    LOG2_N_IN = 4'd0; DATA_SIGNED = 1'b0; CONT = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = {12'hFFF - 12'(3 * i), 12'(37 * i + 5)};
      ADC_DATA_IN = v;
      tick();
      if (DONE !== 1'b1) bad_done++;
      if (AVE_OUT !== v) begin
        bad_ave++;
        $display("FAIL l0_ave_%0d got %h want %h", i, AVE_OUT, v);
      end
    end
    n_checks++; if (bad_done !== 0) $display("FAIL l0_done_low got %0d want 0", bad_done); else n_pass++;
    n_checks++; if (bad_ave !== 0) $display("FAIL l0_ave_count got %0d want 0", bad_ave); else n_pass++;
    CONT = 1'b0;
    v = 24'h123_456;
    ADC_DATA_IN = v;
    tick();
    n_checks++; if (DONE !== 1'b1) $display("FAIL l0_last_done got %b want 1", DONE); else n_pass++;
    n_checks++; if (AVE_OUT !== v) $display("FAIL l0_last_ave got %h want %h", AVE_OUT, v); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL l0_busy got %b want 0", BUSY); else n_pass++;
    tick();
    n_checks++; if (DONE !== 1'b0) $display("FAIL l0_idle_done got %b want 0", DONE); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_clamp();
    test_continuous();
    test_reset_mid();
    test_l0_passthrough();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
